// File: rtl/ahb_pkg.sv
// Shared AHB definitions used by the arbiter and the master multiplexer.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [2:0] HSIZE_4W    = 3'b100;
  localparam logic [2:0] HSIZE_8W    = 3'b101;

  localparam int MAX_MASTERS = 16;
  localparam int MID_W       = $clog2(MAX_MASTERS);

endpackage

// File: rtl/ahb_dp_tracker.sv
// Data-phase ownership registers, saturating handover counter and
// locked-handover error pulse.
module ahb_dp_tracker
  import ahb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [MID_W-1:0] HMASTER,
  input  logic             HMASTLOCK,
  input  logic             HREADY,
  input  logic             htrans_act,
  input  logic             hwrite,
  output logic [MID_W-1:0] dp_master,
  output logic             dp_write,
  output logic [CNT_W-1:0] handover_cnt,
  output logic             lock_violation
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [MID_W-1:0] dp_master_p1;
  logic             dp_active_p1;
  logic             dp_hwrite_p1;
  logic             dp_lock_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             lock_err_p1;
  logic             handover;

  assign handover = HREADY && (HMASTER != dp_master_p1);

  // ---- address phase -> data phase boundary ----
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_master_p1 <= '0;
      dp_active_p1 <= 1'b0;
      dp_hwrite_p1 <= 1'b0;
      dp_lock_p1   <= 1'b0;
      cnt_p1       <= '0;
      lock_err_p1  <= 1'b0;
    end else begin
      lock_err_p1 <= handover && dp_lock_p1;
      if (HREADY) begin
        dp_master_p1 <= HMASTER;
        dp_active_p1 <= htrans_act;
        dp_hwrite_p1 <= htrans_act & hwrite;
        dp_lock_p1   <= HMASTLOCK;
      end
      if (handover)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign dp_master      = dp_master_p1;
  assign dp_write       = dp_active_p1 & dp_hwrite_p1;
  assign handover_cnt   = cnt_p1;
  assign lock_violation = lock_err_p1;

endmodule

// File: rtl/ahb_master_mux.sv
// AHB master-to-slave multiplexer: routes the granted master's address/control
// in the address phase and the data-phase owner's HWDATA one phase later.
module ahb_master_mux
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [3:0]                    HMASTER,
  input  logic                          HMASTLOCK,
  input  logic                          HREADY,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx,
  input  logic [NUM_MASTERS*2-1:0]      HTRANSx,
  input  logic [NUM_MASTERS-1:0]        HWRITEx,
  input  logic [NUM_MASTERS*3-1:0]      HSIZEx,
  input  logic [NUM_MASTERS*3-1:0]      HBURSTx,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx,
  output logic [ADDR_W-1:0]             HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [DATA_W-1:0]             HWDATA,
  output logic [3:0]                    HMASTER_DP,
  output logic                          dp_write,
  output logic [CNT_W-1:0]              handover_cnt,
  output logic                          lock_violation
);

  logic [MID_W-1:0] dp_master;

  // Out-of-range HMASTER matches no slice, leaving IDLE/zero on the bus.
  always_comb begin
    HADDR  = '0;
    HTRANS = IDLE;
    HWRITE = 1'b0;
    HSIZE  = '0;
    HBURST = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (HMASTER == MID_W'(m)) begin
        HADDR  = HADDRx[m*ADDR_W +: ADDR_W];
        HTRANS = HTRANSx[m*2 +: 2];
        HWRITE = HWRITEx[m];
        HSIZE  = HSIZEx[m*3 +: 3];
        HBURST = HBURSTx[m*3 +: 3];
      end
    end
  end

  ahb_dp_tracker #(
    .CNT_W(CNT_W)
  ) u_dp_tracker (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HMASTER       (HMASTER),
    .HMASTLOCK     (HMASTLOCK),
    .HREADY        (HREADY),
    .htrans_act    (HTRANS[1]),
    .hwrite        (HWRITE),
    .dp_master     (dp_master),
    .dp_write      (dp_write),
    .handover_cnt  (handover_cnt),
    .lock_violation(lock_violation)
  );

  // ---- data phase: write data follows the registered owner ----
  always_comb begin
    HWDATA = '0;
    if (dp_write) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (dp_master == MID_W'(m))
          HWDATA = HWDATAx[m*DATA_W +: DATA_W];
      end
    end
  end

  assign HMASTER_DP = dp_master;

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench: a 16-master instance for routing/lock checks and a
// 4-master, 2-bit-counter instance for range and saturation checks.
module tb_ahb_master_mux;

  localparam int NM = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              HCLK;
  logic              HRESET;
  logic [3:0]        HMASTER;
  logic              HMASTLOCK;
  logic              HREADY;
  logic [NM*AW-1:0]  HADDRx;
  logic [NM*2-1:0]   HTRANSx;
  logic [NM-1:0]     HWRITEx;
  logic [NM*3-1:0]   HSIZEx;
  logic [NM*3-1:0]   HBURSTx;
  logic [NM*DW-1:0]  HWDATAx;

  logic [AW-1:0] a_haddr, b_haddr;
  logic [1:0]    a_htrans, b_htrans;
  logic          a_hwrite, b_hwrite;
  logic [2:0]    a_hsize, b_hsize, a_hburst, b_hburst;
  logic [DW-1:0] a_hwdata, b_hwdata;
  logic [3:0]    a_dpm, b_dpm;
  logic          a_dpw, b_dpw;
  logic [15:0]   a_cnt;
  logic [1:0]    b_cnt;
  logic          a_lv, b_lv;

  int total = 0;
  int bad   = 0;

  ahb_master_mux #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HADDRx(HADDRx), .HTRANSx(HTRANSx), .HWRITEx(HWRITEx),
    .HSIZEx(HSIZEx), .HBURSTx(HBURSTx), .HWDATAx(HWDATAx),
    .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite), .HSIZE(a_hsize),
    .HBURST(a_hburst), .HWDATA(a_hwdata), .HMASTER_DP(a_dpm), .dp_write(a_dpw),
    .handover_cnt(a_cnt), .lock_violation(a_lv)
  );

  ahb_master_mux #(.NUM_MASTERS(4), .ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HADDRx(HADDRx[4*AW-1:0]), .HTRANSx(HTRANSx[7:0]),
    .HWRITEx(HWRITEx[3:0]), .HSIZEx(HSIZEx[11:0]), .HBURSTx(HBURSTx[11:0]),
    .HWDATAx(HWDATAx[4*DW-1:0]),
    .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize),
    .HBURST(b_hburst), .HWDATA(b_hwdata), .HMASTER_DP(b_dpm), .dp_write(b_dpw),
    .handover_cnt(b_cnt), .lock_violation(b_lv)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1; HMASTER = 4'd0; HMASTLOCK = 1'b0; HREADY = 1'b1;
    for (int m = 0; m < NM; m++) begin
      HADDRx[m*AW +: AW]  = 32'h2000_0000 + 32'(m) * 32'h100;
      HTRANSx[m*2 +: 2]   = 2'b00;
      HWRITEx[m]          = 1'b1;
      HSIZEx[m*3 +: 3]    = 3'(m);
      HBURSTx[m*3 +: 3]   = 3'(m + 1);
      HWDATAx[m*DW +: DW] = 32'hD000_0000 | 32'(m);
    end
    HADDRx[3*AW +: AW] = 32'h1000_0040;
    tick(); tick();
    HRESET = 1'b0;

    // reset state
    check("rst_dpm", a_dpm, 0);
    check("rst_dpw", a_dpw, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_lv", a_lv, 0);
    check("rst_hwdata", a_hwdata, 0);

    // address phase routing, then data phase of master 3
    HMASTER = 4'd3; HTRANSx[3*2 +: 2] = 2'b10;
    #1;
    check("ap_haddr", a_haddr, 32'h1000_0040);
    check("ap_htrans", a_htrans, 2'b10);
    check("ap_hwrite", a_hwrite, 1);
    check("ap_hsize", a_hsize, 3);
    check("ap_hburst", a_hburst, 4);
    tick();
    check("dp_master3", a_dpm, 3);
    check("dp_write3", a_dpw, 1);
    check("dp_hwdata3", a_hwdata, 32'hD000_0003);
    check("cnt_first", a_cnt, 1);

    // waited handover to master 5
    for (int m = 0; m < NM; m++) HTRANSx[m*2 +: 2] = 2'b10;
    HMASTER = 4'd5; HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wait_hwdata", a_hwdata, 32'hD000_0003);
      check("wait_cnt", a_cnt, 1);
      check("wait_dpm", a_dpm, 3);
    end
    HREADY = 1'b1;
    tick();
    check("ho_cnt", a_cnt, 2);
    check("ho_dpm", a_dpm, 5);
    check("ho_hwdata", a_hwdata, 32'hD000_0005);

    // locked handover
    HMASTER = 4'd1; HMASTLOCK = 1'b1;
    tick();
    check("lk_lv0", a_lv, 0);
    HMASTER = 4'd2; HMASTLOCK = 1'b0;
    tick();
    check("lk_lv1", a_lv, 1);
    check("lk_cnt", a_cnt, 4);
    tick();
    check("lk_lv_clr", a_lv, 0);

    // same sequence unlocked
    HMASTER = 4'd1;
    tick();
    check("ul_lv_a", a_lv, 0);
    HMASTER = 4'd2;
    tick();
    check("ul_lv_b", a_lv, 0);
    check("ul_cnt", a_cnt, 6);

    // reset again, then counter saturation on the 2-bit instance
    HRESET = 1'b1; HMASTER = 4'd0;
    tick();
    HRESET = 1'b0;
    check("rst2_bcnt", b_cnt, 0);
    check("rst2_acnt", a_cnt, 0);
    HMASTER = 4'd1; tick(); check("sat_1", b_cnt, 1);
    HMASTER = 4'd0; tick(); check("sat_2", b_cnt, 2);
    HMASTER = 4'd1; tick(); check("sat_3", b_cnt, 3);
    HMASTER = 4'd0; tick(); check("sat_hold", b_cnt, 3);
    check("sat_acnt", a_cnt, 4);

    // out-of-range master on the 4-master instance
    HMASTER = 4'd7;
    #1;
    check("oor_htrans", b_htrans, 0);
    check("oor_haddr", b_haddr, 0);
    check("oor_hwrite", b_hwrite, 0);
    check("inr_haddr7", a_haddr, 32'h2000_0700);
    tick();
    check("oor_dpw", b_dpw, 0);
    check("oor_hwdata", b_hwdata, 0);
    check("oor_dpm", b_dpm, 7);
    check("inr_hwdata7", a_hwdata, 32'hD000_0007);

    // reset during an active write data phase, overriding HREADY=0
    HMASTER = 4'd3;
    tick();
    check("pre_rst_dpw", a_dpw, 1);
    check("pre_rst_cnt", a_cnt, 6);
    HRESET = 1'b1; HREADY = 1'b0;
    tick();
    check("mid_rst_dpm", a_dpm, 0);
    check("mid_rst_dpw", a_dpw, 0);
    check("mid_rst_hwdata", a_hwdata, 0);
    check("mid_rst_cnt", a_cnt, 0);
    check("mid_rst_lv", a_lv, 0);
    HRESET = 1'b0; HREADY = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
